// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for an RV32I core: issues one data-memory access per
// LOAD/STORE, stalls the core while it runs, and flags misaligned or stuck accesses.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lsb,
  output logic       mem_req,
  output logic       mem_we,
  output logic [3:0] mem_be,
  input  logic       mem_gnt,
  input  logic       mem_rvalid,
  output logic       pc_en,
  output logic       ld_wen,
  output logic       stall,
  output logic       busy,
  output logic       misalign,
  output logic       timeout
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] cnt;
  logic              we_q;
  logic [3:0]        be_q;

  logic       is_mem, is_store, bad_access;
  logic [3:0] be_dec;
  logic       start, req_c, pc_c, ld_c, stall_c, mis_c, to_c, at_limit;

  // The unsigned bit only matters to the load-data extender, not to sequencing.
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;
  assign at_limit = (cnt == CNT_LAST);

  always_comb begin
    be_dec     = 4'b0000;
    bad_access = 1'b0;
    case (funct3[1:0])
      2'b00: be_dec = 4'b0001 << addr_lsb;
      2'b01: begin
        be_dec     = 4'b0011 << addr_lsb;
        bad_access = addr_lsb[0];
      end
      2'b10: begin
        be_dec     = 4'b1111;
        bad_access = (addr_lsb != 2'b00);
      end
      default: bad_access = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      be_q  <= 4'b0000;
    end else begin
      state <= state_n;
      // Counter restarts on every state change so REQ and WAIT each get a full budget.
      if (state_n != state)
        cnt <= '0;
      else if (state == S_REQ || state == S_WAIT)
        cnt <= cnt + WAIT_W'(1);
      if (start) begin
        we_q <= is_store;
        be_q <= be_dec;
      end
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    req_c   = 1'b0;
    pc_c    = 1'b0;
    ld_c    = 1'b0;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    to_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          if (!is_mem) begin
            pc_c = 1'b1;
          end else if (bad_access) begin
            mis_c = 1'b1;
            pc_c  = 1'b1;
          end else begin
            stall_c = 1'b1;
            start   = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        // A grant on the last allowed cycle still counts as progress.
        if (mem_gnt) begin
          if (we_q) begin
            pc_c    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT;
          end
        end else if (at_limit) begin
          to_c    = 1'b1;
          pc_c    = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          state_n = S_WB;
        end else if (at_limit) begin
          to_c    = 1'b1;
          pc_c    = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WB: begin
        ld_c    = 1'b1;
        pc_c    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reset forces every output low immediately, including the combinational ones.
  assign mem_req  = nreset & req_c;
  assign mem_we   = nreset & req_c & we_q;
  assign mem_be   = {4{nreset & req_c}} & be_q;
  assign pc_en    = nreset & pc_c;
  assign ld_wen   = nreset & ld_c;
  assign stall    = nreset & stall_c;
  assign busy     = nreset & (state != S_IDLE);
  assign misalign = nreset & mis_c;
  assign timeout  = nreset & to_c;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int MAX_WAIT = 15;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic       clock = 1'b0;
  logic       nreset;
  logic       instr_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] addr_lsb;
  logic       mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0] mem_be;
  logic       pc_en, ld_wen, stall, busy, misalign, timeout;

  mem_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .nreset(nreset), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .addr_lsb(addr_lsb), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .pc_en(pc_en),
    .ld_wen(ld_wen), .stall(stall), .busy(busy), .misalign(misalign), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one in-flight access described by its progress flags.
  bit         m_acc;      // an access has been issued and is not finished
  bit         m_store;
  logic [3:0] m_be;
  bit         m_granted;  // load accepted, waiting for data
  bit         m_data;     // load data arrived, write-back this cycle
  int         m_waited;   // cycles already spent in the current waiting phase

  logic [11:0] last_out;  // {req,we,be[3:0],pc_en,ld_wen,stall,busy,misalign,timeout}

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h required=%h", name, cyc, got, req);
    end
  endtask

  // Byte lanes from access size: n bytes starting at lsb, aligned only if lsb is a multiple of n.
  function automatic logic [3:0] lanes(input logic [2:0] f3, input logic [1:0] lsb, output bit ill);
    int n;
    int mask;
    n    = 1 << f3[1:0];
    ill  = (n > 4) || ((int'(lsb) % n) != 0);
    mask = ((1 << n) - 1) << lsb;
    return ill ? 4'b0000 : 4'(mask);
  endfunction

  task automatic set_in(input bit v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [1:0] lsb, input bit g, input bit rv);
    instr_valid = v; opcode = op; funct3 = f3; addr_lsb = lsb; mem_gnt = g; mem_rvalid = rv;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    bit e_req, e_pc, e_ld, e_stall, e_busy, e_mis, e_to, ill, is_mem;
    logic [3:0] dbe;
    logic [11:0] e, g;
    bit n_acc, n_store, n_granted, n_data;
    logic [3:0] n_be;
    int n_waited;
    #2;
    {e_req, e_pc, e_ld, e_stall, e_busy, e_mis, e_to} = '0;
    n_acc = m_acc; n_store = m_store; n_be = m_be; n_granted = m_granted;
    n_data = m_data; n_waited = m_waited;
    if (nreset) begin
      if (!m_acc) begin
        if (instr_valid) begin
          is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
          dbe = lanes(funct3, addr_lsb, ill);
          if (!is_mem) e_pc = 1;
          else if (ill) begin e_mis = 1; e_pc = 1; end
          else begin
            e_stall = 1;
            n_acc = 1; n_store = (opcode == OP_STORE); n_be = dbe;
            n_granted = 0; n_data = 0; n_waited = 0;
          end
        end
      end else if (m_data) begin
        e_ld = 1; e_pc = 1; e_busy = 1; n_acc = 0;
      end else if (!m_granted) begin
        e_req = 1; e_stall = 1; e_busy = 1;
        if (mem_gnt) begin
          if (m_store) begin e_pc = 1; n_acc = 0; end
          else begin n_granted = 1; n_waited = 0; end
        end else if (m_waited == MAX_WAIT - 1) begin
          e_to = 1; e_pc = 1; n_acc = 0;
        end else n_waited = m_waited + 1;
      end else begin
        e_stall = 1; e_busy = 1;
        if (mem_rvalid) n_data = 1;
        else if (m_waited == MAX_WAIT - 1) begin e_to = 1; e_pc = 1; n_acc = 0; end
        else n_waited = m_waited + 1;
      end
    end
    g = {mem_req, mem_we, mem_be, pc_en, ld_wen, stall, busy, misalign, timeout};
    e = {e_req, m_store, m_be, e_pc, e_ld, e_stall, e_busy, e_mis, e_to};
    if (!e_req) begin
      g[10:6] = 5'b0;
      e[10:6] = 5'b0;
    end
    last_out = {mem_req, mem_we, mem_be, pc_en, ld_wen, stall, busy, misalign, timeout};
    check("outputs", g, e);
    @(posedge clock);
    if (!nreset) begin
      m_acc = 0; m_store = 0; m_be = 4'b0; m_granted = 0; m_data = 0; m_waited = 0;
    end else begin
      m_acc = n_acc; m_store = n_store; m_be = n_be; m_granted = n_granted;
      m_data = n_data; m_waited = n_waited;
    end
    cyc++;
    @(negedge clock);
  endtask

  function automatic bit o_req();   return last_out[11]; endfunction
  function automatic bit o_pc();    return last_out[5];  endfunction
  function automatic bit o_ld();    return last_out[4];  endfunction
  function automatic bit o_stall(); return last_out[3];  endfunction
  function automatic bit o_busy();  return last_out[2];  endfunction
  function automatic bit o_mis();   return last_out[1];  endfunction
  function automatic bit o_to();    return last_out[0];  endfunction

  initial begin
    int req_cnt, to_at;
    bit starve;
    m_acc = 0; m_store = 0; m_be = 4'b0; m_granted = 0; m_data = 0; m_waited = 0;
    nreset = 1'b0;
    set_in(1, OP_LOAD, 3'b010, 2'b00, 1, 1);
    @(negedge clock);
    step();
    check("reset_outputs", last_out, 12'h000);
    nreset = 1'b1;

    // ADD passes in one cycle
    set_in(1, OP_ADD, 3'b000, 2'b00, 0, 0);
    step();
    check("add_pc_req_busy", 12'({o_pc(), o_req(), o_busy()}), 12'(3'b100));

    // LW lsb=00: gnt at cycle 1, rvalid at cycle 3, write-back at cycle 4
    set_in(1, OP_LOAD, 3'b010, 2'b00, 0, 0);
    step();
    check("lw_issue_req_stall_pc", 12'({o_req(), o_stall(), o_pc()}), 12'(3'b010));
    set_in(0, OP_ADD, 3'b000, 2'b00, 1, 1);
    step();
    check("lw_req_we_be", 12'(last_out[11:6]), 12'(6'b1_0_1111));
    set_in(0, OP_ADD, 3'b000, 2'b00, 0, 0);
    step();
    set_in(0, OP_ADD, 3'b000, 2'b00, 0, 1);
    step();
    check("lw_wait_req_stall_pc_ld", 12'({o_req(), o_stall(), o_pc(), o_ld()}), 12'(4'b0100));
    set_in(0, OP_ADD, 3'b000, 2'b00, 1, 1);
    step();
    check("lw_wb_ld_pc_stall_busy", 12'({o_ld(), o_pc(), o_stall(), o_busy()}), 12'(4'b1101));

    // SH lsb=10 with the grant held off for three cycles
    set_in(1, OP_STORE, 3'b001, 2'b10, 0, 0);
    step();
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(0, OP_ADD, 3'b000, 2'b00, 0, 0);
      step();
      req_cnt += int'(o_req());
    end
    set_in(0, OP_ADD, 3'b000, 2'b00, 1, 0);
    step();
    req_cnt += int'(o_req());
    check("sh_gnt_req_we_be_pc", 12'({last_out[11:6], o_pc()}), 12'(7'b1_1_1100_1));
    check("sh_req_cycles", 12'(req_cnt), 12'd4);
    set_in(0, OP_ADD, 3'b000, 2'b00, 0, 0);
    step();
    check("sh_after_busy_req", 12'({o_busy(), o_req()}), 12'(2'b00));

    // LH lsb=01, SW lsb=10, illegal size: each dropped with misalign
    set_in(1, OP_LOAD, 3'b001, 2'b01, 0, 0);
    step();
    check("lh_mis_pc_req_stall", 12'({o_mis(), o_pc(), o_req(), o_stall()}), 12'(4'b1100));
    set_in(1, OP_STORE, 3'b010, 2'b10, 0, 0);
    step();
    check("sw_mis_pc_req_stall", 12'({o_mis(), o_pc(), o_req(), o_stall()}), 12'(4'b1100));
    set_in(1, OP_LOAD, 3'b011, 2'b00, 0, 0);
    step();
    check("f3_011_mis_pc_req_stall", 12'({o_mis(), o_pc(), o_req(), o_stall()}), 12'(4'b1100));
    set_in(0, OP_ADD, 3'b000, 2'b00, 1, 1);
    step();
    check("mis_pulse_ends", 12'({o_mis(), o_busy()}), 12'(2'b00));

    // LB lsb=11 never granted: times out on the 15th request cycle
    set_in(1, OP_LOAD, 3'b000, 2'b11, 0, 0);
    step();
    req_cnt = 0; to_at = 0;
    for (int i = 1; i <= MAX_WAIT + 5; i++) begin
      set_in(0, OP_ADD, 3'b000, 2'b00, 0, 0);
      step();
      req_cnt += int'(o_req());
      if (o_to()) begin
        to_at = i;
        check("lb_timeout_pc_ld", 12'({o_pc(), o_ld()}), 12'(2'b10));
        break;
      end
    end
    check("lb_timeout_cycle", 12'(to_at), 12'(MAX_WAIT));
    check("lb_req_cycles", 12'(req_cnt), 12'(MAX_WAIT));
    set_in(0, OP_ADD, 3'b000, 2'b00, 0, 0);
    step();
    check("lb_after_busy_req_ld", 12'({o_busy(), o_req(), o_ld()}), 12'(3'b000));

    // Reset in the middle of a load wait, then a late rvalid
    set_in(1, OP_LOAD, 3'b100, 2'b01, 0, 0);
    step();
    set_in(0, OP_ADD, 3'b000, 2'b00, 1, 0);
    step();
    set_in(0, OP_ADD, 3'b000, 2'b00, 0, 0);
    step();
    check("wait_before_reset_busy", 12'({o_busy(), o_stall()}), 12'(2'b11));
    nreset = 1'b0;
    step();
    check("reset_midaccess_outputs", last_out, 12'h000);
    nreset = 1'b1;
    set_in(0, OP_ADD, 3'b000, 2'b00, 0, 1);
    step();
    check("late_rvalid_ld_pc_busy", 12'({o_ld(), o_pc(), o_busy()}), 12'(3'b000));

    // Randomized traffic, including stray handshakes, starved accesses and resets
    starve = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [6:0] op;
      case ($urandom_range(3))
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_ADD;
        default: op = 7'($urandom);
      endcase
      if (!m_acc) starve = ($urandom_range(7) == 0);
      set_in($urandom_range(9) < 7, op, 3'($urandom), 2'($urandom),
             !starve && ($urandom_range(2) == 0), !starve && ($urandom_range(2) == 0));
      nreset = ($urandom_range(299) != 0);
      step();
    end
    nreset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
